// File: rtl/pwm_capture.sv
// Single-channel PWM input capture: high time and rise-to-rise period in prescaled ticks.
// Input rise sampled at edge k gives valid_o in the cycle after edge k+STAGE+1.
module pwm_capture #(
  parameter int CNT_WIDTH  = 32,
  parameter int PSCR_WIDTH = 16,
  parameter int STAGE      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [PSCR_WIDTH-1:0] div_i,
  input  logic                  irq_en_i,
  input  logic                  irq_clr_i,
  input  logic                  pwm_i,
  output logic [CNT_WIDTH-1:0]  period_o,
  output logic [CNT_WIDTH-1:0]  high_o,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic                  ovf_o,
  output logic                  irq_o
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_HIGH, S_LOW} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [STAGE-1:0]      r_sync;
  logic                  r_hist;
  logic [PSCR_WIDTH-1:0] r_div;
  logic [PSCR_WIDTH-1:0] r_psc;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  r_high_q;
  logic                  r_cap_d;

  logic                  w_sync;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_tick;
  logic                  w_busy;
  logic [PSCR_WIDTH-1:0] w_div_eff;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic                  w_load_div;
  logic                  w_start;
  logic                  w_cap_high;
  logic                  w_cap_per;
  logic                  w_sat;

  assign w_sync    = r_sync[STAGE-1];
  assign w_rise    = w_sync & ~r_hist;
  assign w_fall    = ~w_sync & r_hist;
  assign w_div_eff = (div_i == '0) ? PSCR_WIDTH'(1) : div_i;
  assign w_tick    = (r_psc == (r_div - PSCR_WIDTH'(1)));
  assign w_cnt_nxt = r_cnt + CNT_WIDTH'(w_tick);
  assign w_busy    = (r_state == S_HIGH) || (r_state == S_LOW);
  assign busy_o    = w_busy;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else if (clr_i) begin
      r_state <= en_i ? S_ARM : S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Disable beats saturation, which beats edge events.
  always_comb begin
    w_state_nxt = r_state;
    w_load_div  = 1'b0;
    w_start     = 1'b0;
    w_cap_high  = 1'b0;
    w_cap_per   = 1'b0;
    w_sat       = 1'b0;
    if (!en_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_ARM;
          w_load_div  = 1'b1;
        end
        S_ARM: begin
          if (w_rise) begin
            w_state_nxt = S_HIGH;
            w_start     = 1'b1;
          end
        end
        S_HIGH: begin
          if (w_tick && (&r_cnt)) begin
            w_state_nxt = S_ARM;
            w_sat       = 1'b1;
          end else if (w_fall) begin
            w_state_nxt = S_LOW;
            w_cap_high  = 1'b1;
          end
        end
        S_LOW: begin
          if (w_tick && (&r_cnt)) begin
            w_state_nxt = S_ARM;
            w_sat       = 1'b1;
          end else if (w_rise) begin
            w_state_nxt = S_HIGH;
            w_cap_per   = 1'b1;
            w_start     = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_sync   <= '0;
      r_hist   <= 1'b0;
      r_div    <= (!rst_i && en_i) ? w_div_eff : PSCR_WIDTH'(1);
      r_psc    <= '0;
      r_cnt    <= '0;
      r_high_q <= '0;
      r_cap_d  <= 1'b0;
      period_o <= '0;
      high_o   <= '0;
      valid_o  <= 1'b0;
      ovf_o    <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      r_sync  <= {r_sync[STAGE-2:0], pwm_i};
      r_hist  <= w_sync;
      r_cap_d <= w_cap_per;
      valid_o <= r_cap_d;
      if (w_load_div) begin
        r_div <= w_div_eff;
      end
      if (w_start || (w_state_nxt == S_IDLE) || (w_state_nxt == S_ARM)) begin
        r_cnt <= '0;
        r_psc <= '0;
      end else if (w_busy) begin
        r_cnt <= w_cnt_nxt;
        r_psc <= w_tick ? '0 : r_psc + PSCR_WIDTH'(1);
      end
      if (w_cap_high) begin
        r_high_q <= w_cnt_nxt;
      end
      if (w_cap_per) begin
        period_o <= w_cnt_nxt;
        high_o   <= r_high_q;
      end
      if (w_sat) begin
        ovf_o <= 1'b1;
      end
      if (r_cap_d && irq_en_i) begin
        irq_o <= 1'b1;
      end else if (irq_clr_i) begin
        irq_o <= 1'b0;
      end
    end
  end

endmodule
